// File: rtl/sm_sub_sched.sv
// sm_sub_sched -- round-robin front end for one shared 24-bit sign-magnitude
// subtractor. Grants one requester at a time, latches its operands, drives
// one su_en pulse and waits for su_done. A timeout covers a missing
// su_done. The result is returned with a one-cycle one-hot ack.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i[NREQ]        request levels, held until ack
//   a_in_i, b_in_i     packed operands, requester i at [24i+23:24i]
//   ack_o[NREQ]        one-hot result strobe
//   res_o              result, valid while ack_o != 0
//   err_ack_o          marks an acked transaction that timed out
//   err_o              sticky timeout flag
//   busy_o             low only in IDLE
//   op_count_o         completed transactions (wrapping)
//   su_en_o, su_a_o, su_b_o, su_out_i, su_done_i   subtractor handshake
module sm_sub_sched #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [24*NREQ-1:0]   a_in_i,
    input  logic [24*NREQ-1:0]   b_in_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [23:0]          res_o,
    output logic                 err_ack_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [15:0]          op_count_o,
    output logic                 su_en_o,
    output logic [23:0]          su_a_o,
    output logic [23:0]          su_b_o,
    input  logic [23:0]          su_out_i,
    input  logic                 su_done_i
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_DRAIN = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          drain_q, drain_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] g_q, g_d;
    logic [23:0]   su_a_q, su_a_d, su_b_q, su_b_d;
    logic [23:0]   res_q, res_d;
    logic          tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   ops_q, ops_d;

    logic [23:0]   a_arr [NREQ];
    logic [23:0]   b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_in_i[24*i +: 24];
        assign b_arr[i] = b_in_i[24*i +: 24];
    end

    // Round-robin search starting just after the last served requester.
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        su_a_d  = su_a_q;
        su_b_d  = su_b_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ops_d   = ops_q;
        case (state_q)
            // The subtractor has no reset; let any in-flight done fall
            // on the floor for two cycles.
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (found) begin
                    g_d     = win;
                    su_a_d  = a_arr[win];
                    su_b_d  = b_arr[win];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // done has priority over a coincident timeout
                if (su_done_i) begin
                    res_d   = su_out_i;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = g_q;
                ops_d   = ops_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_DRAIN;
            drain_q <= 1'b0;
            ptr_q   <= IW'(NREQ - 1);
            g_q     <= '0;
            su_a_q  <= '0;
            su_b_q  <= '0;
            res_q   <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            su_a_q  <= su_a_d;
            su_b_q  <= su_b_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == S_RESP) ack_o[g_q] = 1'b1;
    end

    assign err_ack_o  = (state_q == S_RESP) && tmo_q;
    assign su_en_o    = (state_q == S_ISSUE);
    assign busy_o     = (state_q != S_IDLE);
    assign res_o      = res_q;
    assign err_o      = err_q;
    assign op_count_o = ops_q;
    assign su_a_o     = su_a_q;
    assign su_b_o     = su_b_q;
endmodule

// File: doc/sm_sub_sched.md
# sm_sub_sched

Round-robin scheduler that shares one 24-bit sign-magnitude subtractor (`sub`, en/done handshake) among NREQ requesters. It latches the winning requester's operands, sequences the subtractor through one operation, captures the result, and returns it with a one-cycle acknowledge. A timeout guards against a missing `done`. It sits between the power-quality correction channels and the single shared subtract unit.

## Interface
- NREQ, 3, number of requesters (2..4)
- TIMEOUT, 8, max cycles waited in WAIT for `su_done` before error
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until ack
- a_in  in  24*NREQ  operand A, requester i at bits [24i+23:24i], sign-magnitude (bit 23 = sign)
- b_in  in  24*NREQ  operand B, same packing
- ack  out  NREQ  one-hot, one-cycle pulse: result for requester i valid
- res  out  24  result; valid only while ack is nonzero
- err_ack  out  1  pulses with ack when the transaction timed out
- err  out  1  sticky timeout flag; cleared only by rst
- busy  out  1  high in every state except IDLE
- op_count  out  16  completed transactions, including timeouts; wraps 0xFFFF->0
- su_en  out  1  enable to subtractor, one-cycle pulse
- su_a  out  24  operand A to subtractor
- su_b  out  24  operand B to subtractor
- su_out  in  24  subtractor result
- su_done  in  1  subtractor completion strobe

## Operation
- States: DRAIN, IDLE, ISSUE, WAIT, RESP.
- Reset: state=DRAIN, drain counter=0, ptr=NREQ-1, ack=0, res=0, err_ack=0, err=0, busy=1, op_count=0, su_en=0, su_a=0, su_b=0.
- DRAIN: the subtractor has no reset and may be mid-operation; stay 2 cycles, ignore su_done, then go to IDLE.
- IDLE: busy=0. If any req bit is high, grant the first set bit searching ptr+1, ptr+2, ... with wraparound modulo NREQ. Latch grant index g, a_in[g] into su_a, b_in[g] into su_b, then go to ISSUE. If no req bit is high, stay in IDLE.
- ISSUE: su_en=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On su_done=1: res<=su_out, go to RESP.
  - If the counter reaches TIMEOUT with no su_done: res<=0, set err, mark timeout, go to RESP.
  - su_done wins if both occur in the same cycle.
- RESP: ack[g]=1, err_ack=timeout mark, ptr<=g, op_count+1, go to IDLE.
- su_a and su_b stay stable from ISSUE through RESP. They change only on the next grant.
- su_done outside WAIT is ignored.
- Requester rule: drop req in the cycle after ack. A req still high in the following IDLE cycle is a new transaction.
- Operands are sampled only at grant. Changes to a_in/b_in afterwards have no effect.
- req dropped before ack: the transaction still completes, and the ack pulse is delivered anyway.
- rst asserted in any state aborts the transaction with no ack and enters DRAIN.

## Timing
- Req first seen high in IDLE cycle T gives: ISSUE at T+1 (su_en=1), WAIT at T+2, su_done at T+3 with the nominal `sub`, RESP and ack at T+4.
- Back-to-back throughput: one operation per 5 cycles.
- After rst deasserts, the earliest grant is in the 3rd IDLE-eligible cycle: 2 DRAIN cycles, then IDLE.
- Timeout path: ack occurs TIMEOUT+2 cycles after ISSUE.

## Test plan
- Single op: req[0]=1, a0=0x000005, b0=0x000003 -> su_en pulses 1 cycle after grant; ack=3'b001 4 cycles after req is sampled; res=0x000002; op_count=1.
- Magnitude reversal: req[1], a1=0x000003, b1=0x000005 -> res=0x800002 (negative 2); a1=b1=0x000010 -> res=0x000000.
- Fairness: req=3'b111 held, each requester dropping req after its own ack and re-raising it 1 cycle later -> grant order 0,1,2,0,1,2; no requester is granted twice in a row while another is waiting.
- Timeout: su_done tied low -> ack with res=0x000000 and err_ack=1 exactly TIMEOUT+2 cycles after su_en; err stays 1 until rst; op_count increments.
- Stray done: pulse su_done during IDLE and ISSUE -> no ack, no state change; the real done in WAIT completes normally.
- Reset mid-op: assert rst for 1 cycle during WAIT -> no ack; err=0; op_count=0; the next grant goes to requester 0 and waits for 2 DRAIN cycles; the result is correct despite a stale su_done during DRAIN.
